// File: rtl/iir_pkg.sv
// Shared definitions for the biquad cascade.
// Holds the coefficient-select encodings, the FSM and MAC-step enums, the
// coefficient values every section wakes up with, and the helper that
// classifies an accumulator value against the DATA_W range.
package iir_pkg;

    // coef_sel encodings; the same index addresses a section's coefficient row
    localparam logic [2:0] SEL_S  = 3'd0;
    localparam logic [2:0] SEL_B0 = 3'd1;
    localparam logic [2:0] SEL_B1 = 3'd2;
    localparam logic [2:0] SEL_B2 = 3'd3;
    localparam logic [2:0] SEL_A1 = 3'd4;
    localparam logic [2:0] SEL_A2 = 3'd5;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_OUT} state_t;

    // MAC order within one section: w from s,a1,a2 then y from b0,b1,b2
    typedef enum logic [2:0] {
        STEP_S, STEP_A1, STEP_A2, STEP_B0, STEP_B1, STEP_B2
    } step_t;

    // Power-on low-pass coefficients, indexed by SEL_*
    localparam int DEF_COEF [6] = '{20, 2048, -3248, 2048, -3558, 1972};

    // Widest accumulator the range check supports
    localparam int ACC_MAX = 128;

    // Returns {above max, below min} of v relative to a dw-bit signed range.
    function automatic logic [1:0] sat_code(input logic signed [ACC_MAX-1:0] v,
                                            input int dw);
        logic signed [ACC_MAX-1:0] hi;
        logic signed [ACC_MAX-1:0] lo;
        hi = (ACC_MAX'(1) <<< (dw - 1)) - ACC_MAX'(1);
        lo = -hi - ACC_MAX'(1);
        return {v > hi, v < lo};
    endfunction

endpackage

// File: rtl/iir_mac.sv
// Shared multiply/accumulate unit.
// Ports:
//   CLK, reset : clock, synchronous active-high reset
//   en         : update the accumulator this cycle
//   clr        : start a new sum (ignore the held accumulator)
//   sub        : subtract the scaled product instead of adding it
//   x, c       : signed sample/state operand and signed coefficient
//   res        : the sum including this cycle's product, reduced to DATA_W
module iir_mac
    import iir_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int COEF_W = 16,
    parameter int FRAC   = 11,
    parameter int SAT    = 1
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     sub,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [COEF_W-1:0] c,
    output logic signed [DATA_W-1:0] res
);

    localparam int PW = DATA_W + COEF_W;
    localparam int AW = PW + 3;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] term;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] base;
    logic signed [AW-1:0] acc_nxt;
    logic [1:0]           code;

    always_comb begin
        prod    = PW'(x) * PW'(c);
        term    = prod >>> FRAC;            // floor toward -inf
        base    = clr ? '0 : acc;
        acc_nxt = sub ? base - AW'(term) : base + AW'(term);
        code    = sat_code(ACC_MAX'(acc_nxt), DATA_W);
        if (SAT != 0 && code[1])
            res = {1'b0, {(DATA_W-1){1'b1}}};
        else if (SAT != 0 && code[0])
            res = {1'b1, {(DATA_W-1){1'b0}}};
        else
            res = acc_nxt[DATA_W-1:0];
    end

    always_ff @(posedge CLK) begin
        if (reset)
            acc <= '0;
        else if (en)
            acc <= acc_nxt;
    end

endmodule

// File: rtl/iir_biquad_cascade.sv
// Cascade of SECTIONS direct-form-II biquads sharing one MAC.
// A sample is accepted in IDLE, each section takes six MAC cycles in CALC,
// and the result is held in OUT until downstream takes it.
// Ports:
//   CLK, reset                      : clock, synchronous active-high reset
//   in_valid/in_ready/in_data       : input sample handshake
//   out_valid/out_ready/out_data    : output sample handshake
//   coef_we/coef_sec/coef_sel/coef_data : coefficient write (IDLE only)
//   coef_err                        : one-cycle pulse for a dropped write
module iir_biquad_cascade
    import iir_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int COEF_W   = 16,
    parameter int FRAC     = 11,
    parameter int SECTIONS = 3,
    parameter int SAT      = 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              coef_we,
    input  logic [2:0]        coef_sec,
    input  logic [2:0]        coef_sel,
    input  logic [COEF_W-1:0] coef_data,
    output logic              coef_err
);

    localparam int            SW   = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
    localparam logic [SW-1:0] LAST = SW'(SECTIONS - 1);

    state_t                   state, state_nxt;
    step_t                    step;
    logic [SW-1:0]            sec;
    logic signed [COEF_W-1:0] coef [SECTIONS][6];
    logic signed [DATA_W-1:0] d1 [SECTIONS];
    logic signed [DATA_W-1:0] d2 [SECTIONS];
    logic signed [DATA_W-1:0] x_reg, w_reg, mac_x, mac_res;
    logic signed [COEF_W-1:0] mac_c;
    logic                     mac_clr, mac_sub, coef_ok, last_step;

    assign last_step = (step == STEP_B2) && (sec == LAST);
    assign coef_ok   = coef_we && (state == ST_IDLE) &&
                       (32'(coef_sec) < SECTIONS) && (coef_sel <= SEL_A2);

    // ---- FSM: state register ----
    always_ff @(posedge CLK) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_CALC;
            ST_CALC: if (last_step) state_nxt = ST_OUT;
            ST_OUT:  if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---- FSM: outputs (gated by reset so an aborted sample never leaks) ----
    always_comb begin
        in_ready  = (state == ST_IDLE) && !reset;
        out_valid = (state == ST_OUT) && !reset;
    end

    // ---- MAC operand selection for the current step ----
    always_comb begin
        mac_x   = x_reg;
        mac_c   = coef[sec][SEL_S];
        mac_clr = 1'b0;
        mac_sub = 1'b0;
        case (step)
            STEP_S:  begin mac_x = x_reg;   mac_c = coef[sec][SEL_S];  mac_clr = 1'b1; end
            STEP_A1: begin mac_x = d1[sec]; mac_c = coef[sec][SEL_A1]; mac_sub = 1'b1; end
            STEP_A2: begin mac_x = d2[sec]; mac_c = coef[sec][SEL_A2]; mac_sub = 1'b1; end
            STEP_B0: begin mac_x = w_reg;   mac_c = coef[sec][SEL_B0]; mac_clr = 1'b1; end
            STEP_B1: begin mac_x = d1[sec]; mac_c = coef[sec][SEL_B1]; end
            STEP_B2: begin mac_x = d2[sec]; mac_c = coef[sec][SEL_B2]; end
            default: ;
        endcase
    end

    iir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .FRAC   (FRAC),
        .SAT    (SAT)
    ) u_mac (
        .CLK   (CLK),
        .reset (reset),
        .en    (state == ST_CALC),
        .clr   (mac_clr),
        .sub   (mac_sub),
        .x     (mac_x),
        .c     (mac_c),
        .res   (mac_res)
    );

    // ---- datapath, coefficient and delay storage ----
    always_ff @(posedge CLK) begin
        if (reset) begin
            sec      <= '0;
            step     <= STEP_S;
            x_reg    <= '0;
            w_reg    <= '0;
            out_data <= '0;
            coef_err <= 1'b0;
            for (int k = 0; k < SECTIONS; k++) begin
                d1[k] <= '0;
                d2[k] <= '0;
                for (int j = 0; j < 6; j++)
                    coef[k][j] <= COEF_W'(DEF_COEF[j]);
            end
        end else begin
            coef_err <= coef_we && !coef_ok;
            // a write in the accept cycle lands before the sample's first MAC
            if (coef_ok)
                coef[coef_sec[SW-1:0]][coef_sel] <= coef_data;
            case (state)
                ST_IDLE: if (in_valid) begin
                    x_reg <= in_data;
                    sec   <= '0;
                    step  <= STEP_S;
                end
                ST_CALC: begin
                    if (step == STEP_A2)
                        w_reg <= mac_res;
                    if (step == STEP_B2) begin
                        d2[sec] <= d1[sec];
                        d1[sec] <= w_reg;
                        x_reg   <= mac_res;     // feeds the next section
                        step    <= STEP_S;
                        if (sec == LAST)
                            out_data <= mac_res;
                        else
                            sec <= sec + SW'(1);
                    end else begin
                        step <= step_t'(step + 3'd1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Self-checking bench for iir_biquad_cascade.
// Instance a: SECTIONS=3, SAT=1. Instance b: SECTIONS=1, SAT=0 (wrap check).
// Sections 1 and 2 of instance a are loaded as exact pass-through so the
// single-section vectors can run on section 0 alone.
module tb_iir_biquad_cascade;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid_a = 1'b0, in_valid_b = 1'b0;
    logic        in_ready_a, in_ready_b;
    logic [31:0] in_data = '0;
    logic        out_valid_a, out_valid_b;
    logic        out_ready = 1'b1;
    logic [31:0] out_data_a, out_data_b;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_sec = '0, coef_sel = '0;
    logic [15:0] coef_data = '0;
    logic        coef_err_a, coef_err_b;

    always #5 CLK = ~CLK;

    iir_biquad_cascade #(.DATA_W(32), .COEF_W(16), .FRAC(11), .SECTIONS(3), .SAT(1)) dut_a (
        .CLK(CLK), .reset(reset),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .coef_we(coef_we), .coef_sec(coef_sec), .coef_sel(coef_sel),
        .coef_data(coef_data), .coef_err(coef_err_a)
    );

    iir_biquad_cascade #(.DATA_W(32), .COEF_W(16), .FRAC(11), .SECTIONS(1), .SAT(0)) dut_b (
        .CLK(CLK), .reset(reset),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .coef_we(coef_we), .coef_sec(coef_sec), .coef_sel(coef_sel),
        .coef_data(coef_data), .coef_err(coef_err_b)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // ---- reference model of the default-coefficient cascade ----
    longint mc [3][6];
    longint md1 [3];
    longint md2 [3];

    function automatic longint clamp32(longint v);
        longint lim;
        lim = 2147483647;
        if (v > lim) return lim;
        if (v < -lim - 1) return -lim - 1;
        return v;
    endfunction

    task automatic model_defaults();
        int dc [6];
        dc = '{20, 2048, -3248, 2048, -3558, 1972};
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 6; j++) mc[k][j] = dc[j];
            md1[k] = 0;
            md2[k] = 0;
        end
    endtask

    task automatic model_step(input longint xin, output longint yout);
        longint x, w, y;
        x = xin;
        for (int k = 0; k < 3; k++) begin
            w = clamp32(((mc[k][0] * x) >>> 11) - ((mc[k][4] * md1[k]) >>> 11)
                        - ((mc[k][5] * md2[k]) >>> 11));
            y = clamp32(((mc[k][1] * w) >>> 11) + ((mc[k][2] * md1[k]) >>> 11)
                        + ((mc[k][3] * md2[k]) >>> 11));
            md2[k] = md1[k];
            md1[k] = w;
            x = y;
        end
        yout = x;
    endtask

    // ---- handshake helpers (all drives happen 1 time unit after posedge) ----
    task automatic start(input bit b, input logic [31:0] din);
        int n;
        n = 0;
        in_data = din;
        if (b) in_valid_b = 1'b1; else in_valid_a = 1'b1;
        while (!(b ? in_ready_b : in_ready_a) && n < 200) begin
            @(posedge CLK); #1; n++;
        end
        chk("accept_wait", b ? in_ready_b : in_ready_a, 1);
        @(posedge CLK); #1;            // accept edge
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    // lat = number of edges from the accept edge to the edge that takes the output
    task automatic finish(input bit b, output logic [31:0] dout, output int lat);
        lat = 0;
        while (!(b ? out_valid_b : out_valid_a) && lat < 500) begin
            @(posedge CLK); #1; lat++;
        end
        chk("out_valid_wait", b ? out_valid_b : out_valid_a, 1);
        dout = b ? out_data_b : out_data_a;
        @(posedge CLK); #1;            // out_ready=1 takes it here
        lat++;
    endtask

    task automatic coef_wr(input int sec, input int sel, input int val);
        coef_we = 1'b1;
        coef_sec = 3'(sec);
        coef_sel = 3'(sel);
        coef_data = 16'(val);
        @(posedge CLK); #1;
        coef_we = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
    endtask

    // section-0 coefficient sets, order s,b0,b1,b2,a1,a2
    int cfg_c [4][6];
    int pass_c [6];

    task automatic load_cfg(input int cfg);
        pulse_reset();
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 6; j++)
                coef_wr(k, j, (k == 0) ? cfg_c[cfg][j] : pass_c[j]);
    endtask

    typedef struct {
        int cfg;
        int din;
        int exp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dout, hold;
        longint      my;
        int          lat, cur_cfg;
        bit          seen;

        pass_c    = '{2048, 2048, 0, 0, 0, 0};
        cfg_c[0]  = '{2048, 2048, 0, 0, 0, 0};       // pass-through
        cfg_c[1]  = '{2048, 2048, 0, 0, -1024, 0};   // first-order feedback
        cfg_c[2]  = '{1024, 2048, 0, 0, 0, 0};       // half gain, floor rounding
        cfg_c[3]  = '{2048, 2048, 2048, 0, 0, 0};    // w + d1, overflows

        tbl[0]  = '{0, 1000, 1000};
        tbl[1]  = '{0, -7, -7};
        tbl[2]  = '{1, 2048, 2048};
        tbl[3]  = '{1, 0, 1024};
        tbl[4]  = '{1, 0, 512};
        tbl[5]  = '{1, 0, 256};
        tbl[6]  = '{1, 0, 128};
        tbl[7]  = '{2, -3, -2};
        tbl[8]  = '{2, 3, 1};
        tbl[9]  = '{3, 'h7FFFFFFF, 'h7FFFFFFF};
        tbl[10] = '{3, 'h7FFFFFFF, 'h7FFFFFFF};
        tbl[11] = '{0, 123456, 123456};
        tbl[12] = '{0, -1, -1};

        // ---- reset state ----
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_in_ready", in_ready_a, 0);
        chk("rst_out_valid", out_valid_a, 0);
        reset = 1'b0;
        @(posedge CLK); #1;
        chk("post_rst_in_ready", in_ready_a, 1);
        chk("post_rst_out_valid", out_valid_a, 0);
        chk("post_rst_out_data", out_data_a, 0);
        chk("post_rst_coef_err", coef_err_a, 0);

        // ---- default coefficients, impulse from zero state ----
        model_defaults();
        for (int i = 0; i < 4; i++) begin
            start(0, (i == 0) ? 32'(1 << 24) : 32'd0);
            finish(0, dout, lat);
            model_step((i == 0) ? longint'(1 << 24) : 0, my);
            chk($sformatf("default_imp%0d", i), $signed(dout), my);
        end

        // ---- table vectors ----
        cur_cfg = -1;
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].cfg != cur_cfg) begin
                load_cfg(tbl[i].cfg);
                cur_cfg = tbl[i].cfg;
            end
            start(0, 32'(tbl[i].din));
            finish(0, dout, lat);
            chk($sformatf("vec%0d_data", i), $signed(dout), tbl[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, 6 * 3 + 1);
        end

        // ---- wrap: single section, SAT=0, sat config on section 0 ----
        load_cfg(3);
        start(1, 32'h7FFFFFFF);
        finish(1, dout, lat);
        chk("wrap_first", $signed(dout), 'h7FFFFFFF);
        chk("wrap_latency", lat, 6 * 1 + 1);
        start(1, 32'h7FFFFFFF);
        finish(1, dout, lat);
        chk("wrap_second", $signed(dout), -2);

        // ---- backpressure ----
        load_cfg(0);
        out_ready = 1'b0;
        start(0, 32'd1234);
        lat = 0;
        while (!out_valid_a && lat < 500) begin @(posedge CLK); #1; lat++; end
        chk("bp_valid", out_valid_a, 1);
        hold = out_data_a;
        chk("bp_data", $signed(hold), 1234);
        in_valid_a = 1'b1;             // must not be taken while OUT holds
        in_data = 32'd77;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            chk($sformatf("bp_hold%0d", i),
                {out_valid_a, in_ready_a, out_data_a}, {1'b1, 1'b0, 32'd1234});
        end
        in_valid_a = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK); #1;
        chk("bp_release_valid", out_valid_a, 0);
        chk("bp_release_ready", in_ready_a, 1);

        // ---- coefficient write during CALC is dropped ----
        start(0, 32'd1000);
        repeat (3) begin @(posedge CLK); #1; end
        coef_wr(0, 0, 1024);
        chk("calc_wr_err", coef_err_a, 1);
        @(posedge CLK); #1;
        chk("calc_wr_err_clear", coef_err_a, 0);
        finish(0, dout, lat);
        chk("calc_wr_unchanged", $signed(dout), 1000);

        // ---- bad index writes in IDLE, and a good one ----
        coef_wr(0, 6, 5);
        chk("bad_sel_err", coef_err_a, 1);
        coef_wr(3, 0, 5);
        chk("bad_sec_err", coef_err_a, 1);
        coef_wr(1, 1, 2048);
        chk("good_wr_err", coef_err_a, 0);

        // ---- write and sample in the same IDLE cycle: new s applies ----
        coef_we = 1'b1; coef_sec = 3'd0; coef_sel = 3'd0; coef_data = 16'd1024;
        in_data = 32'd1000; in_valid_a = 1'b1;
        @(posedge CLK); #1;
        coef_we = 1'b0; in_valid_a = 1'b0;
        finish(0, dout, lat);
        chk("same_cycle_wr", $signed(dout), 500);
        chk("same_cycle_latency", lat, 6 * 3 + 1);
        coef_wr(0, 0, 2048);

        // ---- reset during step 3 of section 1 ----
        start(0, 32'd1000);             // delays now nonzero
        finish(0, dout, lat);
        start(0, 32'd5000);
        repeat (9) begin @(posedge CLK); #1; end
        reset = 1'b1;
        @(posedge CLK); #1;
        chk("abort_in_ready", in_ready_a, 0);
        chk("abort_out_valid", out_valid_a, 0);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK); #1;
            if (out_valid_a) seen = 1'b1;
        end
        chk("abort_no_output", seen, 0);
        chk("abort_out_data", out_data_a, 0);
        model_defaults();
        for (int i = 0; i < 4; i++) begin
            start(0, (i == 0) ? 32'(1 << 24) : 32'd0);
            finish(0, dout, lat);
            model_step((i == 0) ? longint'(1 << 24) : 0, my);
            chk($sformatf("post_abort_imp%0d", i), $signed(dout), my);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
